// File: rtl/md_sched.sv
// MIPS multiply/divide unit: holds HI/LO, models MD latency with a busy counter, raises D-stage stall.
// Optional: define MDU_DIV0_FLAG_EN to add a one-cycle div0 pulse when a zero-divisor divide completes.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_MDen,
  output logic        busy,
  output logic        D_stall,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic        div0
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [63:0] pend_q;
  logic        pend_z_q;
  logic        busy_q;
`ifdef MDU_DIV0_FLAG_EN
  logic        div0_q;
`endif

  logic        is_md;
  logic [63:0] mul_s, mul_u, res_d;
  logic        sgn, a_neg, b_neg, div_z;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign is_md = E_start && (E_md_op <= 3'd3);

  assign mul_s = $signed({{32{E_rs[31]}}, E_rs}) * $signed({{32{E_rt[31]}}, E_rt});
  assign mul_u = {32'b0, E_rs} * {32'b0, E_rt};

  // Signed divide via magnitudes; negating 0x80000000 wraps to itself, which yields the
  // required 0x80000000 / -1 result without a special case.
  assign sgn    = ~E_md_op[0];
  assign a_neg  = sgn & E_rs[31];
  assign b_neg  = sgn & E_rt[31];
  assign a_mag  = a_neg ? -E_rs : E_rs;
  assign b_mag  = b_neg ? -E_rt : E_rt;
  assign div_z  = (E_rt == 32'd0);
  assign b_safe = div_z ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem    = a_neg ? -r_mag : r_mag;

  always_comb begin
    res_d = {rem, quo};
    case (E_md_op)
      3'd0:    res_d = mul_s;
      3'd1:    res_d = mul_u;
      default: res_d = {rem, quo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      pend_q   <= 64'd0;
      pend_z_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      div0_q   <= 1'b0;
`endif
    end else begin
`ifdef MDU_DIV0_FLAG_EN
      div0_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (is_md) begin
            pend_q   <= res_d;
            pend_z_q <= E_md_op[1] & div_z;
            cnt_q    <= E_md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else if (E_start && E_md_op == 3'd4) begin
            hi_q <= E_rs;
          end else if (E_start && E_md_op == 3'd5) begin
            lo_q <= E_rs;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!pend_z_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
`ifdef MDU_DIV0_FLAG_EN
            div0_q <= pend_z_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign D_stall = D_MDen & (busy_q | is_md);
  assign out_hi  = hi_q;
  assign out_lo  = lo_q;
`ifdef MDU_DIV0_FLAG_EN
  assign div0    = div0_q;
`endif

endmodule
